flght_cntrl_pipe: RTL and testbench

//  Parametrised, pipelined successor of the quadcopter PD flight controller. It takes

---
 rtl/flght_cntrl_pkg.sv | 31 +++
 rtl/flght_cntrl_pipe_pd_axis.sv | 90 +++++++++
 rtl/flght_cntrl_pipe.sv | 167 ++++++++++++++++
 tb/tb_flght_cntrl_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/flght_cntrl_pkg.sv
// Shared definitions for the pipelined PD flight controller.
//   axis_t       : names the three control axes, used to index per-axis arrays
//   MIN_RUN_DEF  : default idle offset added to thrust
//   CAL_SPD_DEF  : default motor speed forced while the inertial unit calibrates
//   sat_signed() : clamps a 17-bit signed value to a narrower signed range
package flght_cntrl_pkg;

  typedef enum logic [1:0] {PTCH, ROLL, YAW} axis_t;

  localparam int MIN_RUN_DEF = 'h2A5;
  localparam int CAL_SPD_DEF = 'h1B0;

  // Clamp val to [-(2^(width-1)), 2^(width-1)-1]; the result stays 17 bits wide
  // so callers size-cast it down to the field they actually store.
  function automatic logic signed [16:0] sat_signed(input logic signed [16:0] val,
                                                     input int width);
    int lim_hi;
    int lim_lo;
    int v;
    lim_hi = (1 << (width - 1)) - 1;
    lim_lo = -(1 << (width - 1));
    v = int'(val);
    if (v > lim_hi) begin
      v = lim_hi;
    end else if (v < lim_lo) begin
      v = lim_lo;
    end
    return 17'(v);
  endfunction

endpackage

// File: rtl/flght_cntrl_pipe_pd_axis.sv
// One control axis of the PD flight controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   capture    : stage-1 enable, latch the saturated error for this sample
//   update     : stage-2 enable, push the latched error into the D queue
//   cal_clr    : calibration active, clear write pointer and fill count
//   meas, des  : measured and desired angle (signed 16 bits)
//   p_term     : proportional term (signed 16 bits, combinational from stage 1)
//   d_term     : derivative term (signed 16 bits), zero until the queue is warm
//   q_full     : queue holds D_Q_DEPTH samples
module pd_axis
  import flght_cntrl_pkg::*;
#(
  parameter int ERR_W     = 10,
  parameter int DIFF_W    = 7,
  parameter int D_COEF    = 7,
  parameter int D_Q_DEPTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        update,
  input  logic        cal_clr,
  input  logic [15:0] meas,
  input  logic [15:0] des,
  output logic [15:0] p_term,
  output logic [15:0] d_term,
  output logic        q_full
);

  localparam int PTR_W = (D_Q_DEPTH > 1) ? $clog2(D_Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(D_Q_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(D_Q_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(D_Q_DEPTH);
  localparam logic signed [15:0] D_COEF_S = 16'(D_COEF);

  logic signed [ERR_W-1:0] err_q, err_d;
  logic signed [ERR_W-1:0] queue_q [D_Q_DEPTH];
  logic signed [ERR_W-1:0] queue_d [D_Q_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic signed [16:0]      err_raw, diff_raw;
  logic signed [15:0]      err_ext, diff_ext, p_mul, d_mul;

  // The 17-bit difference cannot overflow for any pair of 16-bit angles.
  assign err_raw  = $signed({meas[15], meas}) - $signed({des[15], des});
  // The entry at wptr is the oldest sample; it is read before being overwritten.
  assign diff_raw = 17'(err_q) - 17'(queue_q[wptr_q]);
  assign err_ext  = 16'(err_q);
  assign diff_ext = 16'(sat_signed(diff_raw, DIFF_W));
  assign p_mul    = err_ext * 16'sd5;
  assign p_term   = p_mul >>> 3;
  assign d_mul    = diff_ext * D_COEF_S;
  assign q_full   = (fill_q == FULL_CNT);
  // Until the queue is warm its oldest entry is not a real past sample.
  assign d_term   = q_full ? d_mul : '0;

  always_comb begin
    err_d   = capture ? ERR_W'(sat_signed(err_raw, ERR_W)) : err_q;
    queue_d = queue_q;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    if (cal_clr) begin
      wptr_d = '0;
      fill_d = '0;
    end else if (update) begin
      queue_d[wptr_q] = err_q;
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
      if (fill_q != FULL_CNT) begin
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < D_Q_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else begin
      err_q   <= err_d;
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      queue_q <= queue_d;
    end
  end

endmodule

// File: rtl/flght_cntrl_pipe.sv
// Pipelined PD quadcopter flight controller: three pd_axis instances feed a
// motor mixer with clipping, an optional slew limiter and a calibration override.
//   clk, rst_n             : clock, asynchronous active-low reset
//   vld                    : 1-cycle strobe, new inertial sample present
//   inertial_cal           : calibration in progress, forces CAL_SPD on all motors
//   d_ptch/d_roll/d_yaw    : desired angles (signed 16)
//   ptch/roll/yaw          : measured angles (signed 16)
//   thrst                  : thrust (unsigned 9)
//   frnt/bck/lft/rght_spd  : registered motor speeds, valid two cycles after vld
//   spd_vld                : 1-cycle strobe aligned with the speed update
//   q_full                 : every axis D queue is warm
module flght_cntrl_pipe
  import flght_cntrl_pkg::*;
#(
  parameter int ERR_W     = 10,
  parameter int DIFF_W    = 7,
  parameter int D_COEF    = 7,
  parameter int D_Q_DEPTH = 12,
  parameter int SPD_W     = 11,
  parameter int MIN_RUN   = MIN_RUN_DEF,
  parameter int CAL_SPD   = CAL_SPD_DEF,
  parameter int MAX_STEP  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic             inertial_cal,
  input  logic [15:0]      d_ptch,
  input  logic [15:0]      d_roll,
  input  logic [15:0]      d_yaw,
  input  logic [15:0]      ptch,
  input  logic [15:0]      roll,
  input  logic [15:0]      yaw,
  input  logic [8:0]       thrst,
  output logic [SPD_W-1:0] frnt_spd,
  output logic [SPD_W-1:0] bck_spd,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             spd_vld,
  output logic             q_full
);

  localparam int SPD_MAX = (1 << SPD_W) - 1;
  localparam logic [SPD_W-1:0] CAL_V = SPD_W'(CAL_SPD);

  logic [15:0] meas_a [3];
  logic [15:0] des_a  [3];
  logic [15:0] p_a    [3];
  logic [15:0] d_a    [3];
  logic [2:0]  full_a;

  logic s1_vld_q, s1_live_q, spd_vld_q;
  logic upd;
  logic signed [13:0] base, pp, dp, pr, dr, py, dy;
  logic signed [13:0] mix_a [4];
  logic [SPD_W-1:0]   spd_q [4];
  logic [SPD_W-1:0]   spd_d [4];
  logic [SPD_W-1:0]   tgt_q [4];
  logic [SPD_W-1:0]   tgt_d [4];

  function automatic logic [SPD_W-1:0] clip_spd(input logic signed [13:0] v);
    if (v < 0) return '0;
    else if (int'(v) > SPD_MAX) return SPD_W'(SPD_MAX);
    else return SPD_W'(v);
  endfunction

  function automatic logic [SPD_W-1:0] slew_spd(input logic [SPD_W-1:0] cur,
                                                input logic [SPD_W-1:0] tgt);
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (MAX_STEP == 0) return tgt;
    else if (t > c + MAX_STEP) return SPD_W'(c + MAX_STEP);
    else if (t < c - MAX_STEP) return SPD_W'(c - MAX_STEP);
    else return tgt;
  endfunction

  assign meas_a[int'(PTCH)] = ptch;
  assign meas_a[int'(ROLL)] = roll;
  assign meas_a[int'(YAW)]  = yaw;
  assign des_a[int'(PTCH)]  = d_ptch;
  assign des_a[int'(ROLL)]  = d_roll;
  assign des_a[int'(YAW)]   = d_yaw;

  // A sample that arrives while calibrating, or is in stage 2 when calibration
  // starts, never reaches the queues or the speed targets.
  assign upd = s1_live_q & ~inertial_cal;

  for (genvar g = 0; g < 3; g++) begin : g_axis
    pd_axis #(
      .ERR_W    (ERR_W),
      .DIFF_W   (DIFF_W),
      .D_COEF   (D_COEF),
      .D_Q_DEPTH(D_Q_DEPTH)
    ) u_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .capture(vld & ~inertial_cal),
      .update (upd),
      .cal_clr(inertial_cal),
      .meas   (meas_a[g]),
      .des    (des_a[g]),
      .p_term (p_a[g]),
      .d_term (d_a[g]),
      .q_full (full_a[g])
    );
  end

  assign base = $signed(14'(thrst) + 14'(MIN_RUN));
  assign pp   = 14'($signed(p_a[int'(PTCH)]));
  assign dp   = 14'($signed(d_a[int'(PTCH)]));
  assign pr   = 14'($signed(p_a[int'(ROLL)]));
  assign dr   = 14'($signed(d_a[int'(ROLL)]));
  assign py   = 14'($signed(p_a[int'(YAW)]));
  assign dy   = 14'($signed(d_a[int'(YAW)]));

  assign mix_a[0] = base - pp - dp - py - dy;
  assign mix_a[1] = base + pp + dp - py - dy;
  assign mix_a[2] = base - pr - dr + py + dy;
  assign mix_a[3] = base + pr + dr + py + dy;

  // The target holds the latest mixed speed; with the limiter enabled the
  // outputs keep walking toward it every cycle after the update that set it.
  // Calibration parks both at CAL_SPD so the first update afterwards slews from there.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tgt_d[i] = tgt_q[i];
      spd_d[i] = spd_q[i];
      if (inertial_cal) begin
        tgt_d[i] = CAL_V;
        spd_d[i] = CAL_V;
      end else begin
        if (upd) begin
          tgt_d[i] = clip_spd(mix_a[i]);
        end
        spd_d[i] = slew_spd(spd_q[i], tgt_d[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_live_q <= 1'b0;
      spd_vld_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        spd_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      s1_vld_q  <= vld;
      s1_live_q <= vld & ~inertial_cal;
      spd_vld_q <= s1_vld_q;
      spd_q     <= spd_d;
      tgt_q     <= tgt_d;
    end
  end

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];
  assign spd_vld  = spd_vld_q;
  assign q_full   = &full_a;

endmodule

// File: tb/tb_flght_cntrl_pipe.sv
// Directed bench for flght_cntrl_pipe: one instance with the limiter disabled
// and one with MAX_STEP = 16, both driven by the same stimulus.
module tb_flght_cntrl_pipe;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic        inertial_cal;
  logic [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
  logic [8:0]  thrst;

  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        spd_vld, q_full;
  logic [10:0] s_frnt_spd, s_bck_spd, s_lft_spd, s_rght_spd;
  logic        s_spd_vld, s_q_full;

  int compared;
  int mismatched;

  flght_cntrl_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (vld),
    .inertial_cal(inertial_cal),
    .d_ptch      (d_ptch),
    .d_roll      (d_roll),
    .d_yaw       (d_yaw),
    .ptch        (ptch),
    .roll        (roll),
    .yaw         (yaw),
    .thrst       (thrst),
    .frnt_spd    (frnt_spd),
    .bck_spd     (bck_spd),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .spd_vld     (spd_vld),
    .q_full      (q_full)
  );

  flght_cntrl_pipe #(.MAX_STEP(16)) dut_slew (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (vld),
    .inertial_cal(inertial_cal),
    .d_ptch      (d_ptch),
    .d_roll      (d_roll),
    .d_yaw       (d_yaw),
    .ptch        (ptch),
    .roll        (roll),
    .yaw         (yaw),
    .thrst       (thrst),
    .frnt_spd    (s_frnt_spd),
    .bck_spd     (s_bck_spd),
    .lft_spd     (s_lft_spd),
    .rght_spd    (s_rght_spd),
    .spd_vld     (s_spd_vld),
    .q_full      (s_q_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One vld pulse at a negedge; returns at the negedge after the update edge.
  task automatic applyStimulus(input logic [15:0] p, input logic [15:0] y,
                               input logic [8:0] t);
    ptch  = p;
    yaw   = y;
    thrst = t;
    vld   = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    vld          = 1'b0;
    inertial_cal = 1'b0;
    d_ptch = '0; d_roll = '0; d_yaw = '0;
    ptch   = '0; roll   = '0; yaw   = '0;
    thrst  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_frnt", 16'(frnt_spd), 16'h0);
    checkOutput("rst_bck", 16'(bck_spd), 16'h0);
    checkOutput("rst_lft", 16'(lft_spd), 16'h0);
    checkOutput("rst_rght", 16'(rght_spd), 16'h0);
    checkOutput("rst_spd_vld", 16'(spd_vld), 16'h0);
    checkOutput("rst_q_full", 16'(q_full), 16'h0);
    checkOutput("rst_slew_frnt", 16'(s_frnt_spd), 16'h0);
    rst_n = 1'b1;

    // Calibration forces CAL_SPD one cycle later, no vld required
    $display("[TB] calibration override");
    inertial_cal = 1'b1;
    @(negedge clk);
    checkOutput("cal_frnt", 16'(frnt_spd), 16'h1B0);
    checkOutput("cal_bck", 16'(bck_spd), 16'h1B0);
    checkOutput("cal_lft", 16'(lft_spd), 16'h1B0);
    checkOutput("cal_rght", 16'(rght_spd), 16'h1B0);
    checkOutput("cal_slew_frnt", 16'(s_frnt_spd), 16'h1B0);
    applyStimulus(16'h0, 16'h0, 9'h100);
    checkOutput("cal_spd_vld", 16'(spd_vld), 16'h1);
    checkOutput("cal_q_full", 16'(q_full), 16'h0);
    checkOutput("cal_hold_frnt", 16'(frnt_spd), 16'h1B0);
    inertial_cal = 1'b0;

    // Zero error warm-up: twelve updates, q_full rises with the last one
    $display("[TB] warm-up with zero error");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h0, 16'h0, 9'h100);
      checkOutput("warm_spd_vld", 16'(spd_vld), 16'h1);
      checkOutput("warm_frnt", 16'(frnt_spd), 16'h3A5);
      checkOutput("warm_q_full", 16'(q_full), (i == 11) ? 16'h1 : 16'h0);
    end
    checkOutput("warm_bck", 16'(bck_spd), 16'h3A5);
    checkOutput("warm_lft", 16'(lft_spd), 16'h3A5);
    checkOutput("warm_rght", 16'(rght_spd), 16'h3A5);
    @(negedge clk);
    checkOutput("idle_spd_vld", 16'(spd_vld), 16'h0);

    // Saturated pitch error: P = 319, D = 63*7 = 441
    $display("[TB] pitch step");
    applyStimulus(16'h7FFF, 16'h0, 9'h100);
    checkOutput("step_frnt", 16'(frnt_spd), 16'h0AD);
    checkOutput("step_bck", 16'(bck_spd), 16'h69D);
    checkOutput("step_lft", 16'(lft_spd), 16'h3A5);
    checkOutput("step_rght", 16'(rght_spd), 16'h3A5);
    checkOutput("step_spd_vld", 16'(spd_vld), 16'h1);

    // Same step with zero thrust: front clips at 0
    applyStimulus(16'h7FFF, 16'h0, 9'h000);
    checkOutput("clip_frnt", 16'(frnt_spd), 16'h000);
    checkOutput("clip_bck", 16'(bck_spd), 16'h59D);
    checkOutput("clip_lft", 16'(lft_spd), 16'h2A5);

    // Negative yaw saturation: err -512, P = -320, D = -64*7 = -448
    d_yaw = 16'h7FFF;
    applyStimulus(16'h0, 16'h8000, 9'h100);
    d_yaw = 16'h0;
    checkOutput("yaw_frnt", 16'(frnt_spd), 16'h6A5);
    checkOutput("yaw_bck", 16'(bck_spd), 16'h6A5);
    checkOutput("yaw_lft", 16'(lft_spd), 16'h0A5);
    checkOutput("yaw_rght", 16'(rght_spd), 16'h0A5);

    // Slew limiter
    $display("[TB] slew limiter");
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_frnt", 16'(frnt_spd), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h0, 16'h0, 9'h100);
    end
    repeat (80) @(negedge clk);
    checkOutput("slew_settle_frnt", 16'(s_frnt_spd), 16'h3A5);
    checkOutput("slew_q_full", 16'(s_q_full), 16'h1);
    applyStimulus(16'h7FFF, 16'h0, 9'h100);
    checkOutput("slew_step1_frnt", 16'(s_frnt_spd), 16'h395);
    checkOutput("slew_step1_bck", 16'(s_bck_spd), 16'h3B5);
    checkOutput("slew_step1_spd_vld", 16'(s_spd_vld), 16'h1);
    checkOutput("nolim_step_frnt", 16'(frnt_spd), 16'h0AD);
    @(negedge clk);
    checkOutput("slew_step2_frnt", 16'(s_frnt_spd), 16'h385);
    repeat (60) @(negedge clk);
    checkOutput("slew_hold_frnt", 16'(s_frnt_spd), 16'h0AD);

    // Calibration in the middle of a ramp
    applyStimulus(16'h0, 16'h0, 9'h100);
    checkOutput("ramp_up_frnt", 16'(s_frnt_spd), 16'h0BD);
    inertial_cal = 1'b1;
    @(negedge clk);
    checkOutput("slew_cal_frnt", 16'(s_frnt_spd), 16'h1B0);
    checkOutput("nolim_cal_frnt", 16'(frnt_spd), 16'h1B0);
    inertial_cal = 1'b0;
    // Queues are cold again, so D = 0 and the target is 933 - 319 = 0x266
    applyStimulus(16'h7FFF, 16'h0, 9'h100);
    checkOutput("exit_slew_frnt", 16'(s_frnt_spd), 16'h1C0);
    checkOutput("exit_nolim_frnt", 16'(frnt_spd), 16'h266);
    checkOutput("exit_q_full", 16'(q_full), 16'h0);
    repeat (40) @(negedge clk);
    checkOutput("exit_settle_frnt", 16'(s_frnt_spd), 16'h266);

    // Reset in the middle of a ramp
    applyStimulus(16'h0, 16'h0, 9'h100);
    checkOutput("ramp2_frnt", 16'(s_frnt_spd), 16'h276);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_slew_frnt", 16'(s_frnt_spd), 16'h0);
    checkOutput("midrst_frnt", 16'(frnt_spd), 16'h0);
    checkOutput("midrst_spd_vld", 16'(spd_vld), 16'h0);
    checkOutput("midrst_q_full", 16'(q_full), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
